// File: rtl/snake_pkg.sv
// Shared snake-game types: heading encoding, coordinate width, reset heading.
package snake_pkg;

  typedef enum logic [1:0] {
    WAY_UP    = 2'd0,
    WAY_DOWN  = 2'd1,
    WAY_LEFT  = 2'd2,
    WAY_RIGHT = 2'd3
  } way_t;

  localparam int   COORD_W   = 7;
  localparam way_t WAY_RESET = WAY_RIGHT;

  // Up/down and left/right differ only in the low bit.
  function automatic way_t opposite(input way_t w);
    return way_t'({w[1], ~w[0]});
  endfunction

endpackage

// File: rtl/set_head_if.sv
// Head-step bus: current heading/buttons/head in, registered new heading/head out.
interface set_head_if;
  import snake_pkg::*;

  way_t               way;
  logic [3:0]         push;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  way_t               new_way;
  logic [COORD_W-1:0] new_head_x;
  logic [COORD_W-1:0] new_head_y;

  modport master (
    output way, push, head_x, head_y,
    input  new_way, new_head_x, new_head_y
  );

  modport slave (
    input  way, push, head_x, head_y,
    output new_way, new_head_x, new_head_y
  );
endinterface

// File: rtl/set_head_way_select.sv
// Combinational heading select: one-hot active-low button decode with reversal veto.
module way_select
  import snake_pkg::*;
(
  input  way_t       way,
  input  logic [3:0] push,
  output way_t       way_new
);

  logic [3:0] pressed;
  logic       one_hot;
  way_t       req;

  always_comb begin
    pressed = ~push;
    one_hot = (pressed != 4'b0000) && ((pressed & (pressed - 4'd1)) == 4'b0000);
    req     = way;
    unique case (pressed)
      4'b0001: req = WAY_UP;
      4'b0010: req = WAY_DOWN;
      4'b0100: req = WAY_LEFT;
      4'b1000: req = WAY_RIGHT;
      default: req = way;
    endcase

    way_new = way;
    if (one_hot && (req != opposite(way)))
      way_new = req;
  end

endmodule

// File: rtl/set_head.sv
// Snake head step: select heading, clamp head, step one cell, register outputs.
// Define SET_HEAD_WRAP_EN to wrap at the playfield edges instead of saturating.
module set_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48
) (
  input  logic       clk,
  input  logic       rst,
  set_head_if.slave  bus
);

`ifdef SET_HEAD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic [7:0] Y_MAX = 8'(GRID_H - 1);

  way_t       way_w;
  logic [7:0] x_c;
  logic [7:0] y_c;
  logic [7:0] x_n;
  logic [7:0] y_n;

  way_select u_way_select (
    .way     (bus.way),
    .push    (bus.push),
    .way_new (way_w)
  );

  always_comb begin
    x_c = {1'b0, bus.head_x};
    y_c = {1'b0, bus.head_y};
    if (x_c > X_MAX) x_c = X_MAX;
    if (y_c > Y_MAX) y_c = Y_MAX;

    x_n = x_c;
    y_n = y_c;
    unique case (way_w)
      WAY_UP: begin
        if (y_c == 8'd0) y_n = WRAP ? Y_MAX : 8'd0;
        else             y_n = y_c - 8'd1;
      end
      WAY_DOWN: begin
        if (y_c == Y_MAX) y_n = WRAP ? 8'd0 : Y_MAX;
        else              y_n = y_c + 8'd1;
      end
      WAY_LEFT: begin
        if (x_c == 8'd0) x_n = WRAP ? X_MAX : 8'd0;
        else             x_n = x_c - 8'd1;
      end
      WAY_RIGHT: begin
        if (x_c == X_MAX) x_n = WRAP ? 8'd0 : X_MAX;
        else              x_n = x_c + 8'd1;
      end
      default: begin
        x_n = x_c;
        y_n = y_c;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.new_way    <= WAY_RESET;
      bus.new_head_x <= '0;
      bus.new_head_y <= '0;
    end else begin
      bus.new_way    <= way_w;
      bus.new_head_x <= x_n[COORD_W-1:0];
      bus.new_head_y <= y_n[COORD_W-1:0];
    end
  end

endmodule

// File: tb/tb_set_head.sv
// Scoreboard bench for set_head: directed cases plus randomized steps against a reference model.
module tb_set_head;
  import snake_pkg::*;

  localparam int GW = 64;
  localparam int GH = 48;

`ifdef SET_HEAD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int    w;
    int    x;
    int    y;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  set_head_if bus ();

  set_head #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: count pressed buttons, veto the reversal, clamp, step, then wrap or saturate.
  function automatic exp_t model(input bit r, input int way, input logic [3:0] push,
                                 input int hx, input int hy, input string name);
    exp_t e;
    int   opp[4] = '{1, 0, 3, 2};
    int   dx[4]  = '{0, 0, -1, 1};
    int   dy[4]  = '{-1, 1, 0, 0};
    int   cnt = 0;
    int   req = 0;
    int   w, x, y;
    e.name = name;
    if (r) begin
      e.w = 3; e.x = 0; e.y = 0;
      return e;
    end
    for (int i = 0; i < 4; i++)
      if (push[i] == 1'b0) begin cnt++; req = i; end
    w = (cnt == 1 && req != opp[way]) ? req : way;
    x = (hx < GW - 1) ? hx : GW - 1;
    y = (hy < GH - 1) ? hy : GH - 1;
    x = x + dx[w];
    y = y + dy[w];
    if (WRAP) begin
      x = (x + GW) % GW;
      y = (y + GH) % GH;
    end else begin
      x = (x < 0) ? 0 : ((x > GW - 1) ? GW - 1 : x);
      y = (y < 0) ? 0 : ((y > GH - 1) ? GH - 1 : y);
    end
    e.w = w; e.x = x; e.y = y;
    return e;
  endfunction

  task automatic drive(input bit r, input int way, input logic [3:0] push,
                       input int hx, input int hy, input exp_t e);
    @(negedge clk);
    rst        = r;
    bus.way    = way_t'(way[1:0]);
    bus.push   = push;
    bus.head_x = hx[6:0];
    bus.head_y = hy[6:0];
    sb.push_back(e);
  endtask

  task automatic directed(input bit r, input int way, input logic [3:0] push,
                          input int hx, input int hy,
                          input int ew, input int ex, input int ey, input string name);
    exp_t e;
    e.w = ew; e.x = ex; e.y = ey; e.name = name;
    drive(r, way, push, hx, hy, e);
  endtask

  // Monitor: one registered result per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (int'(bus.new_way) != e.w || int'(bus.new_head_x) != e.x ||
            int'(bus.new_head_y) != e.y) begin
          n_bad++;
          $display("FAIL %s: got way=%0d x=%0d y=%0d, want way=%0d x=%0d y=%0d",
                   e.name, bus.new_way, bus.new_head_x, bus.new_head_y, e.w, e.x, e.y);
        end
      end
    end
  end

  initial begin
    logic [3:0] push;
    int         way, hx, hy;
    bit         r;

    bus.way    = WAY_UP;
    bus.push   = 4'b1111;
    bus.head_x = '0;
    bus.head_y = '0;

    directed(1, 0, 4'b1110, 7, 7, 3, 0, 0, "reset_a");
    directed(1, 2, 4'b1011, 9, 3, 3, 0, 0, "reset_b");
    directed(0, 0, 4'b1111, 1, 1, 0, 1, 0, "release_up");

    directed(0, 2, 4'b1110, 5, 5, 0, 5, 4, "press_up");
    directed(0, 2, 4'b1101, 5, 5, 1, 5, 6, "press_down");
    directed(0, 2, 4'b1011, 5, 5, 2, 4, 5, "press_same");
    directed(0, 2, 4'b0111, 5, 5, 2, 4, 5, "veto_left");

    directed(0, 0, 4'b1101, 5, 5, 0, 5, 4, "veto_up");
    directed(0, 1, 4'b1110, 5, 5, 1, 5, 6, "veto_down");
    directed(0, 3, 4'b1011, 5, 5, 3, 6, 5, "veto_right");
    directed(0, 3, 4'b1100, 5, 5, 3, 6, 5, "multi_press");

    directed(0, 0, 4'b1111, 0, 0, 0, 0, WRAP ? 47 : 0, "edge_top");
    directed(0, 3, 4'b1111, 63, 10, 3, WRAP ? 0 : 63, 10, "edge_right");
    directed(0, 2, 4'b1111, 0, 5, 2, WRAP ? 63 : 0, 5, "edge_left");
    directed(0, 1, 4'b1111, 5, 47, 1, 5, WRAP ? 0 : 47, "edge_bottom");
    directed(0, 1, 4'b1111, 100, 100, 1, 63, WRAP ? 0 : 47, "clamp_down");
    directed(0, 2, 4'b1111, 100, 20, 2, 62, 20, "clamp_left");

    directed(1, 3, 4'b0111, 10, 10, 3, 0, 0, "reset_mid");
    directed(0, 3, 4'b0111, 10, 10, 3, 11, 10, "after_reset");

    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 24) == 0);
      way = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) push = ~(4'b0001 << $urandom_range(0, 3));
      else                           push = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        hx = ($urandom_range(0, 1) != 0) ? 0 : GW - 1;
        hy = ($urandom_range(0, 1) != 0) ? 0 : GH - 1;
      end else begin
        hx = $urandom_range(0, 127);
        hy = $urandom_range(0, 127);
      end
      drive(r, way, push, hx, hy, model(r, way, push, hx, hy, "random"));
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results never observed, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
